// File: rtl/bram_arb_pkg.sv
// Purpose: shared types and helpers for bram_port_arbiter (index width, grant index, one-hot decode).
// Latency: none, compile-time definitions only.
// Backpressure: not applicable.
package bram_arb_pkg;

   localparam int MAX_REQ   = 8;
   localparam int MAX_IDX_W = 3;

   // Grant index sized for the largest supported requester count.
   typedef logic [MAX_IDX_W-1:0] grant_idx_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Decode a one-hot (or zero) vector into its bit index.
   function automatic grant_idx_t onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      grant_idx_t idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | grant_idx_t'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: pick one eligible requester; round-robin after ptr, or fixed priority when BRAM_ARB_FIXED_PRIO_EN is defined.
// Latency: purely combinational, grant valid in the same cycle as eligible.
// Backpressure: none of its own; ineligible requesters are simply never granted.
module rr_picker
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
   // The pointer has no meaning in fixed-priority mode.
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Lowest eligible index wins.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && eligible[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   // Search starts one past the last winner and wraps, so every requester gets a turn.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && eligible[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Purpose: share one single-port BRAM among NUM_REQ requesters; BRAM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: request accepted and BRAM driven in the same cycle; read data on rsp_* from the next cycle.
// Backpressure: a read is only accepted when its response slot is free or being consumed; held responses are buffered.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_we,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wrdata,
   output logic [NUM_REQ-1:0]                rsp_valid,
   input  logic [NUM_REQ-1:0]                rsp_ready,
   output logic [NUM_REQ*DATA_WIDTH-1:0]     rsp_data,
   output logic                              bram_en,
   output logic [DATA_WIDTH/8-1:0]           bram_we,
   output logic [ADDR_WIDTH-1:0]             bram_addr,
   output logic [DATA_WIDTH-1:0]             bram_wrdata,
   input  logic [DATA_WIDTH-1:0]             bram_rddata
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    rd_fire;
   logic [NUM_REQ-1:0]    consume;
   logic [NUM_REQ-1:0]    latched;
   logic [DATA_WIDTH-1:0] rsp_buf [NUM_REQ];
   logic [IDX_W-1:0]      ptr;

   // Writes always qualify; reads need somewhere to put their response next cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (|req_we[i*BE_W +: BE_W]) begin
            eligible[i] = req_valid[i];
         end else begin
            eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]);
         end
      end
      if (rst) begin
         eligible = '0;
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (grant)
   );

`ifdef BRAM_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   grant_idx_t grant_idx;
   assign grant_idx = onehot_to_idx(MAX_REQ'(grant));

   // Remember the last winner; reset so that requester 0 is first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= IDX_W'(NUM_REQ - 1);
      end else if (|grant) begin
         ptr <= grant_idx[IDX_W-1:0];
      end
   end
`endif

   assign req_ready = grant;
   assign bram_en   = |grant;

   // Steer the granted requester's command onto the BRAM port; idle means no write strobes.
   always_comb begin
      bram_we     = '0;
      bram_addr   = '0;
      bram_wrdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            bram_we     = req_we[i*BE_W +: BE_W];
            bram_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            bram_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Per-requester read launches and response handshakes.
   always_comb begin
      rd_fire = '0;
      consume = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_fire[i] = grant[i] && !(|req_we[i*BE_W +: BE_W]);
         consume[i] = rsp_valid[i] && rsp_ready[i];
      end
   end

   // Response slot state: a new read wins over consumption so back-to-back reads keep valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         latched   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_fire[i]) begin
               rsp_valid[i] <= 1'b1;
               latched[i]   <= 1'b0;
            end else if (consume[i]) begin
               rsp_valid[i] <= 1'b0;
               latched[i]   <= 1'b0;
            end else if (rsp_valid[i] && !latched[i]) begin
               latched[i]   <= 1'b1;
            end
         end
      end
   end

   // BRAM data is only present for one cycle, so stalled responses take a copy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_valid[i] && !rsp_ready[i] && !latched[i]) begin
            rsp_buf[i] <= bram_rddata;
         end
      end
   end

   // Fresh responses come straight from the BRAM; held ones from the copy.
   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = latched[i] ? rsp_buf[i] : bram_rddata;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Purpose: self-checking bench for bram_port_arbiter with a BRAM model, queue-based reference model and directed cases.
// Latency: checks combinational outputs in the cycle of the request and responses from the following cycle.
// Backpressure: random and directed rsp_ready stalls; BRAM_ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
module tb_bram_port_arbiter;

   localparam int NR = 3;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*BW-1:0]  req_we;
   logic [NR*DW-1:0]  req_wrdata;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [NR*DW-1:0]  rsp_data;
   logic              bram_en;
   logic [BW-1:0]     bram_we;
   logic [AW-1:0]     bram_addr;
   logic [DW-1:0]     bram_wrdata;
   logic [DW-1:0]     bram_rddata;

   logic [DW-1:0]     mem [256];
   logic              mem_ready = 1'b0;
   logic [DW-1:0]     old_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_we      (req_we),
      .req_wrdata  (req_wrdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .bram_en     (bram_en),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_wrdata (bram_wrdata),
      .bram_rddata (bram_rddata)
   );

   // BRAM model: read-first, data valid one cycle after enable, garbage otherwise.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int a = 0; a < 256; a++) begin
            mem[a] <= (a == 16) ? 32'h0000_00A5 : (32'h1000_0000 ^ (a * 32'h9E37_79B9));
         end
         mem_ready <= 1'b1;
      end else if (bram_en) begin
         bram_rddata <= mem[bram_addr];
         for (int b = 0; b < BW; b++) begin
            if (bram_we[b]) begin
               mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
            end
         end
      end else begin
         bram_rddata <= $urandom;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rd(input int i);
      return rsp_data[i*DW +: DW];
   endfunction

   // Reference model: one queue of expected read data per requester.
   logic [DW-1:0] exp_q [NR][$];
   int            mptr = NR - 1;

   always @(negedge clk) begin
      logic [NR-1:0] elig;
      logic [NR-1:0] g;
      int            gi;
      int            bestd;
      int            d;
      if (rst) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_bram_en", bram_en, 0);
         chk("rst_bram_we", bram_we, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         for (int i = 0; i < NR; i++) exp_q[i].delete();
         mptr = NR - 1;
      end else begin
         elig = '0;
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && (req_we[i*BW +: BW] != 0 || exp_q[i].size() == 0 || rsp_ready[i]))
               elig[i] = 1'b1;
         end
         gi = -1;
         bestd = NR + 1;
         for (int i = 0; i < NR; i++) begin
            if (elig[i]) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
               d = i;
`else
               d = (i - mptr - 1 + 2 * NR) % NR;
`endif
               if (d < bestd) begin
                  bestd = d;
                  gi = i;
               end
            end
         end
         g = '0;
         if (gi >= 0) g[gi] = 1'b1;
         chk("m_req_ready", req_ready, g);
         chk("m_bram_en", bram_en, (gi >= 0));
         if (gi >= 0) begin
            chk("m_bram_addr", bram_addr, req_addr[gi*AW +: AW]);
            chk("m_bram_we", bram_we, req_we[gi*BW +: BW]);
            chk("m_bram_wrdata", bram_wrdata, req_wrdata[gi*DW +: DW]);
         end else begin
            chk("m_idle_we", bram_we, 0);
         end
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("m_rsp_valid%0d", i), rsp_valid[i], (exp_q[i].size() > 0));
            if (exp_q[i].size() > 0)
               chk($sformatf("m_rsp_data%0d", i), rd(i), exp_q[i][0]);
         end
         for (int i = 0; i < NR; i++) begin
            if (exp_q[i].size() > 0 && rsp_ready[i]) void'(exp_q[i].pop_front());
         end
         if (gi >= 0) begin
            if (req_we[gi*BW +: BW] == 0) exp_q[gi].push_back(mem[req_addr[gi*AW +: AW]]);
            mptr = gi;
         end
      end
   end

   typedef struct {
      logic [NR-1:0] vld;
      logic [NR-1:0] wr;
      logic [NR-1:0] exp_rr;
      logic [NR-1:0] exp_fp;
   } gvec_t;

   gvec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wrdata = '0;
      rsp_ready  = '0;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] we, input logic [DW-1:0] dat);
      req_valid[i]          = 1'b1;
      req_addr[i*AW +: AW]  = a;
      req_we[i*BW +: BW]    = we;
      req_wrdata[i*DW +: DW] = dat;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [NR-1:0] e;
      tbl[0] = '{3'b111, 3'b101, 3'b001, 3'b001};
      tbl[1] = '{3'b111, 3'b010, 3'b010, 3'b001};
      tbl[2] = '{3'b111, 3'b111, 3'b100, 3'b001};
      tbl[3] = '{3'b110, 3'b100, 3'b010, 3'b010};
      tbl[4] = '{3'b101, 3'b001, 3'b100, 3'b001};
      tbl[5] = '{3'b011, 3'b011, 3'b001, 3'b001};
      tbl[6] = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[7] = '{3'b100, 3'b000, 3'b100, 3'b100};
      tbl[8] = '{3'b011, 3'b010, 3'b001, 3'b001};
      tbl[9] = '{3'b110, 3'b110, 3'b010, 3'b010};

      rst = 1'b1;
      idle_inputs();
      req_valid = '1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_bram_en", bram_en, 0);
      tick();
      do_reset();

      // Single read held by backpressure for three cycles.
      set_req(0, 8'h10, '0, '0);
      @(negedge clk);
      chk("t1_grant", req_ready, 3'b001);
      chk("t1_addr", bram_addr, 8'h10);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t1_valid_n1", rsp_valid[0], 1);
      chk("t1_data_n1", rd(0), 32'hA5);
      repeat (2) begin
         tick();
         @(negedge clk);
         chk("t1_hold_data", rd(0), 32'hA5);
      end
      tick();
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("t1_valid_consume", rsp_valid[0], 1);
      chk("t1_data_consume", rd(0), 32'hA5);
      tick();
      rsp_ready = '0;
      @(negedge clk);
      chk("t1_cleared", rsp_valid[0], 0);

      // Contention between two continuous writers.
      do_reset();
      set_req(0, 8'h40, 4'hF, $urandom);
      set_req(1, 8'h41, 4'hF, $urandom);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
`ifdef BRAM_ARB_FIXED_PRIO_EN
         chk("t2_grant", req_ready, 3'b001);
`else
         chk("t2_grant", req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
`endif
         chk("t2_en", bram_en, 1);
         tick();
      end

      // Grant table with every response slot always draining.
      do_reset();
      rsp_ready = '1;
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < NR; i++) begin
            if (tbl[r].vld[i]) set_req(i, AW'(8'h80 + i), tbl[r].wr[i] ? 4'hF : 4'h0, $urandom);
            else req_valid[i] = 1'b0;
         end
`ifdef BRAM_ARB_FIXED_PRIO_EN
         e = tbl[r].exp_fp;
`else
         e = tbl[r].exp_rr;
`endif
         @(negedge clk);
         chk($sformatf("tbl%0d_grant", r), req_ready, e);
         chk($sformatf("tbl%0d_en", r), bram_en, |e);
         tick();
      end
      req_valid = '0;
      tick();

      // Backpressure gating on requester 1 while requester 0 streams reads.
      do_reset();
      set_req(1, 8'h20, '0, '0);
      @(negedge clk);
      chk("t4_first", req_ready, 3'b010);
      tick();
      for (int k = 0; k < 3; k++) begin
         set_req(0, AW'(8'h30 + k), '0, '0);
         set_req(1, 8'h21, '0, '0);
         rsp_ready = 3'b001;
         @(negedge clk);
         chk("t4_gated", req_ready, 3'b001);
         chk("t4_held_valid", rsp_valid[1], 1);
         chk("t4_held_data", rd(1), mem[8'h20]);
         tick();
      end
      req_valid[0] = 1'b0;
      rsp_ready = 3'b011;
      @(negedge clk);
      chk("t4_release_grant", req_ready, 3'b010);
      chk("t4_release_data", rd(1), mem[8'h20]);
      tick();
      req_valid = '0;
      rsp_ready = 3'b010;
      @(negedge clk);
      chk("t4_refill_valid", rsp_valid[1], 1);
      chk("t4_refill_data", rd(1), mem[8'h21]);
      tick();
      rsp_ready = '0;
      @(negedge clk);
      chk("t4_drained", rsp_valid, 0);

      // Back-to-back reads.
      do_reset();
      rsp_ready = 3'b001;
      for (int k = 1; k <= 4; k++) begin
         if (k <= 3) set_req(0, AW'(k), '0, '0);
         else req_valid = '0;
         @(negedge clk);
         if (k > 1) begin
            chk("t5_valid", rsp_valid[0], 1);
            chk("t5_data", rd(0), mem[k-1]);
         end
         tick();
      end
      @(negedge clk);
      chk("t5_empty", rsp_valid[0], 0);

      // Partial write then read of the same word.
      do_reset();
      old_w = mem[5];
      rsp_ready = 3'b001;
      set_req(0, 8'h05, 4'h3, 32'h0000_DEAD);
      @(negedge clk);
      chk("t6_we", bram_we, 4'h3);
      chk("t6_en", bram_en, 1);
      tick();
      set_req(0, 8'h05, '0, '0);
      @(negedge clk);
      chk("t6_rd_grant", req_ready, 3'b001);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t6_rd_valid", rsp_valid[0], 1);
      chk("t6_rd_data", rd(0), {old_w[31:16], 16'hDEAD});
      tick();

      // Reset arriving one cycle after a read fire.
      do_reset();
      set_req(0, 8'h07, '0, '0);
      @(negedge clk);
      chk("t7_fire", req_ready, 3'b001);
      tick();
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("t7_rst_valid", rsp_valid, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t7_post_valid", rsp_valid, 0);
      tick();
      set_req(0, 8'h50, 4'hF, $urandom);
      set_req(1, 8'h51, 4'hF, $urandom);
      @(negedge clk);
      chk("t7_first_grant", req_ready, 3'b001);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("t7_no_rsp", rsp_valid, 0);
      tick();

      // Random traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NR; i++) begin
            req_valid[i]           = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]   = AW'($urandom_range(0, 63));
            req_we[i*BW +: BW]     = ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0;
            req_wrdata[i*DW +: DW] = $urandom;
            rsp_ready[i]           = ($urandom_range(0, 2) != 0);
         end
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      rsp_ready = '1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-ported BRAM (1-cycle read latency) between NUM_REQ requesters.
- Typical requesters are AXI-lite-to-BRAM controllers or DMA engines.
- Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Sequencing:
  - Round-robin grant, at most one BRAM access per cycle.
  - Each read response is routed back to its issuer and held until it is consumed.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 64, BRAM data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, BRAM word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address; slice i belongs to requester i.
- req_we  in  NUM_REQ*DATA_WIDTH/8  byte write enables; all-zero means read.
- req_wrdata  in  NUM_REQ*DATA_WIDTH  write data.
- rsp_valid  out  NUM_REQ  read data available.
- rsp_ready  in  NUM_REQ  read data consumed.
- rsp_data  out  NUM_REQ*DATA_WIDTH  read data per requester.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wrdata  out  DATA_WIDTH  BRAM write data.
- bram_rddata  in  DATA_WIDTH  BRAM read data, valid the cycle after the enable, for that one cycle only.

Behaviour:
- Eligibility:
  - Requester i is eligible when req_valid[i] is high.
  - Additionally, if it is a read (req_we slice == 0), its response slot must be free or freeing: !rsp_valid[i] || rsp_ready[i].
  - Writes are always eligible.
- Grant:
  - Combinational round-robin over eligible requesters.
  - Search starts at ptr+1 and wraps modulo NUM_REQ.
  - req_ready = grant (one-hot); the fire is the grant.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Pointer:
  - ptr <= granted index on any fire; otherwise unchanged.
  - Reset value is NUM_REQ-1, so requester 0 wins first.
- BRAM drive, combinational, same cycle as the fire:
  - bram_en = |grant.
  - bram_addr, bram_wrdata and bram_we are muxed from the granted slice.
  - With no grant: bram_we = 0 and bram_addr/bram_wrdata are don't-care.
- Writes: complete when accepted; no response is produced.
- Read latency:
  - Read fire in cycle N → rsp_valid[i]=1 from cycle N+1.
  - rsp_data[i] = bram_rddata in cycle N+1.
- Response hold:
  - If rsp_valid[i] && !rsp_ready[i] && !latched[i], capture bram_rddata into that requester's buffer and set latched[i].
  - From then on rsp_data[i] comes from the buffer.
  - Consumption (rsp_valid && rsp_ready) clears rsp_valid[i] and latched[i].
- Simultaneous events:
  - Consumption and a new read fire for the same requester in the same cycle: rsp_valid[i] stays 1, latched[i] clears, and the next cycle shows new bram_rddata.
  - Other requesters' held responses are unaffected by a BRAM read of a different requester.
- Ordering: strictly in issue order per requester. At most one read is outstanding per requester, guaranteed by the eligibility rule.
- Same-address hazards: read-after-write ordering follows issue order; read-during-write mode is the BRAM's own.
- Reset:
  - While rst is high: req_ready=0, bram_en=0, bram_we=0, rsp_valid=0, latched=0, ptr=NUM_REQ-1.
  - Reset mid-read discards the outstanding read; no response appears after release.
- Idle: when nothing is eligible, bram_en=0 and no state changes except response consumption.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; ptr is neither implemented nor updated.
- Undefined (default): round-robin as above.
- Eligibility, latency and response rules are identical in both modes.

Decomposition:
- Package bram_arb_pkg holds:
  - localparam function for index width, $clog2(NUM_REQ) with a minimum of 1.
  - typedef for the grant index.
  - helper function one-hot→index.
- Sub-module rr_picker (combinational):
  - Inputs: eligible vector, ptr. Output: one-hot grant.
  - Contains the macro-selected fixed-priority variant.
- The top level holds ptr, per-requester rsp_valid/latched/buffer, and the BRAM mux.

Test Plan:
- Single read: req0 reads addr 0x10 (BRAM holds 0xA5); rsp_ready held low 3 cycles → rsp_valid0 from N+1, rsp_data0 stays 0xA5 while bram_rddata changes, clears one cycle after rsp_ready.
- Contention: req0 and req1 both assert continuous writes → grants alternate 0,1,0,1 with bram_en=1 every cycle; with BRAM_ARB_FIXED_PRIO_EN only req0 is granted.
- Backpressure gating: req1 holds a response (rsp_ready1=0) and issues another read → req_ready1=0 while req0 reads proceed every cycle; raising rsp_ready1 grants req1 in that same cycle.
- Back-to-back reads: req0 reads addresses 1,2,3 with rsp_ready0=1 → rsp_data0 shows mem[1],mem[2],mem[3] on consecutive cycles with rsp_valid0 continuously high.
- Write then read: req0 writes 0xDEAD with bram_we=0x03 to addr 5, then reads addr 5 → only the low two bytes are updated, and the response returns in order.
- Reset mid-read: assert rst in cycle N+1 after a read fire → rsp_valid=0 during and after reset, ptr=NUM_REQ-1, first grant after release goes to req0.
